// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register file with context save/restore.
// Holds the transfer FSM state encoding, default parameter values and the
// beat/counter sizing helpers used by reg_file_ctx and reg_file_xfer_ctrl.
package reg_file_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NREGS    = 32;
  localparam int unsigned DEF_XFER_W   = 128;
  localparam int unsigned DEF_ZERO_REG = 1;
  localparam int unsigned DEF_BYPASS   = 1;

  // Legacy encodings kept so waveforms and external tooling stay comparable.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAVE    = 2'd1;
  localparam logic [1:0] ST_RESTORE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SAVE    = ST_SAVE,
    RESTORE = ST_RESTORE
  } state_t;

  // Number of XFER_W beats needed to move the whole array.
  function automatic int unsigned beats_f(input int unsigned nregs,
                                          input int unsigned data_w,
                                          input int unsigned xfer_w);
    return (nregs * data_w) / xfer_w;
  endfunction

  // Beat counter width; never below one bit.
  function automatic int unsigned cnt_w_f(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/reg_file_ctx_if.sv
// Context transfer channel of the register file.
// Carries the save/restore requests, BUSYWAIT/DONE status and the two
// valid/ready beat streams (SAVE_* from the engine, RESTORE_* into it).
// master: the register file engine. slave: the context-switch / debug agent.
interface reg_file_ctx_if #(
  parameter int unsigned XFER_W = 128
);
  logic              SAVE_REQ;
  logic              RESTORE_REQ;
  logic              BUSYWAIT;
  logic              DONE;
  logic [XFER_W-1:0] SAVE_DATA;
  logic              SAVE_VALID;
  logic              SAVE_READY;
  logic [XFER_W-1:0] RESTORE_DATA;
  logic              RESTORE_VALID;
  logic              RESTORE_READY;

  modport master (
    input  SAVE_REQ, RESTORE_REQ, SAVE_READY, RESTORE_DATA, RESTORE_VALID,
    output BUSYWAIT, DONE, SAVE_DATA, SAVE_VALID, RESTORE_READY
  );

  modport slave (
    output SAVE_REQ, RESTORE_REQ, SAVE_READY, RESTORE_DATA, RESTORE_VALID,
    input  BUSYWAIT, DONE, SAVE_DATA, SAVE_VALID, RESTORE_READY
  );
endinterface

// File: rtl/reg_file_xfer_ctrl.sv
// Save/restore sequencer: FSM, beat counter, handshake qualifiers and DONE.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   save_req/restore_req  start requests, sampled only in IDLE (save wins)
//   save_ready            consumer accepts the current save beat
//   restore_valid         producer offers the current restore beat
//   idle                  FSM in IDLE (pipeline writes allowed)
//   cnt                   index of the beat currently being moved
//   save_valid            save beat on offer
//   restore_ready         restore beat will be accepted
//   save_fire/restore_fire handshake completes this cycle
//   busywait              pipeline stall
//   done                  one-cycle pulse in the first IDLE cycle after a transfer
module reg_file_xfer_ctrl
  import reg_file_pkg::*;
#(
  parameter int unsigned BEATS = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             save_req,
  input  logic             restore_req,
  input  logic             save_ready,
  input  logic             restore_valid,
  output logic             idle,
  output logic [CNT_W-1:0] cnt,
  output logic             save_valid,
  output logic             restore_ready,
  output logic             save_fire,
  output logic             restore_fire,
  output logic             busywait,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  state_t state;

  assign idle          = (state == IDLE);
  assign save_valid    = (state == SAVE);
  assign restore_ready = (state == RESTORE);
  assign save_fire     = save_valid & save_ready;
  assign restore_fire  = restore_ready & restore_valid;
  // The DONE cycle is still reported busy so the stall covers request + BEATS
  // cycles; the FSM is already IDLE there and can take a new request.
  assign busywait      = ~idle | done;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (save_req) begin
            state <= SAVE;
          end else if (restore_req) begin
            state <= RESTORE;
          end
        end
        SAVE, RESTORE: begin
          if (save_fire || restore_fire) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_file_ctx.sv
// CPU register file: two combinational read ports, one synchronous write
// port and a streamed context save/restore engine over an XFER_W channel.
// Ports:
//   CLK, RESET               clock, synchronous active-high reset
//   WRITE, INADDRESS, IN     pipeline write (honoured in IDLE only)
//   OUTADDRESS1/2, OUT1/2    combinational reads with optional write bypass
//   xfer                     save/restore channel (reg_file_ctx_if.master)
// The array is flattened with REG[0] in the LSBs; beat k is bits
// [k*XFER_W +: XFER_W].
module reg_file_ctx
  import reg_file_pkg::*;
#(
  parameter  int unsigned DATA_W   = DEF_DATA_W,
  parameter  int unsigned NREGS    = DEF_NREGS,
  parameter  int unsigned XFER_W   = DEF_XFER_W,
  parameter  int unsigned ZERO_REG = DEF_ZERO_REG,
  parameter  int unsigned BYPASS   = DEF_BYPASS,
  localparam int unsigned ADDR_W   = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] OUTADDRESS1,
  input  logic [ADDR_W-1:0] OUTADDRESS2,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  reg_file_ctx_if.master    xfer
);

  localparam int unsigned TOTAL_W = NREGS * DATA_W;
  localparam int unsigned BEATS   = beats_f(NREGS, DATA_W, XFER_W);
  localparam int unsigned CNT_W   = cnt_w_f(BEATS);

  logic [TOTAL_W-1:0] arr;
  logic [TOTAL_W-1:0] arr_next;
  logic               idle;
  logic [CNT_W-1:0]   cnt;
  logic               save_valid;
  logic               save_fire;
  logic               restore_fire;
  logic               wr_ok;
  logic [ADDR_W-1:0]  raddr [2];
  logic [DATA_W-1:0]  rdata [2];

  reg_file_xfer_ctrl #(
    .BEATS (BEATS),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .CLK           (CLK),
    .RESET         (RESET),
    .save_req      (xfer.SAVE_REQ),
    .restore_req   (xfer.RESTORE_REQ),
    .save_ready    (xfer.SAVE_READY),
    .restore_valid (xfer.RESTORE_VALID),
    .idle          (idle),
    .cnt           (cnt),
    .save_valid    (save_valid),
    .restore_ready (xfer.RESTORE_READY),
    .save_fire     (save_fire),
    .restore_fire  (restore_fire),
    .busywait      (xfer.BUSYWAIT),
    .done          (xfer.DONE)
  );

  // A pipeline write is only real in IDLE and never to a hardwired x0.
  assign wr_ok = WRITE & idle & ~((ZERO_REG != 0) && (INADDRESS == '0));

  always_comb begin
    arr_next = arr;
    if (wr_ok) begin
      arr_next[int'(INADDRESS) * DATA_W +: DATA_W] = IN;
    end
    if (restore_fire) begin
      arr_next[int'(cnt) * XFER_W +: XFER_W] = xfer.RESTORE_DATA;
    end
    if (ZERO_REG != 0) begin
      arr_next[DATA_W-1:0] = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      arr <= '0;
    end else begin
      arr <= arr_next;
    end
  end

  assign raddr[0] = OUTADDRESS1;
  assign raddr[1] = OUTADDRESS2;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rdata[p] = arr[int'(raddr[p]) * DATA_W +: DATA_W];
      if ((BYPASS != 0) && wr_ok && (INADDRESS == raddr[p])) begin
        rdata[p] = IN;
      end
      if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
        rdata[p] = '0;
      end
    end
  end

  assign OUT1 = rdata[0];
  assign OUT2 = rdata[1];

  // Array is frozen outside IDLE, so the offered beat is stable under stall.
  assign xfer.SAVE_VALID = save_valid;
  assign xfer.SAVE_DATA  = save_valid ? arr[int'(cnt) * XFER_W +: XFER_W] : '0;

endmodule

// File: tb/tb_reg_file_ctx.sv
module tb_reg_file_ctx;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int XW = 128;
  localparam int NB = 8;
  localparam int RPB = XW / DW;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          WRITE;
  logic [4:0]    INADDRESS;
  logic [DW-1:0] IN;
  logic [4:0]    OUTADDRESS1;
  logic [4:0]    OUTADDRESS2;
  logic [DW-1:0] OUT1;
  logic [DW-1:0] OUT2;

  reg_file_ctx_if #(.XFER_W(XW)) xif ();

  reg_file_ctx #(
    .DATA_W   (DW),
    .NREGS    (NR),
    .XFER_W   (XW),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .WRITE       (WRITE),
    .INADDRESS   (INADDRESS),
    .IN          (IN),
    .OUTADDRESS1 (OUTADDRESS1),
    .OUTADDRESS2 (OUTADDRESS2),
    .OUT1        (OUT1),
    .OUT2        (OUT2),
    .xfer        (xif.master)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: register contents plus transfer mode/beat.
  logic [DW-1:0] mregs [NR];
  int            mmode;   // 0 idle, 1 save, 2 restore
  int            mbeat;
  bit            mdone;

  function automatic logic [DW-1:0] m_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (mmode == 0 && WRITE && INADDRESS == a) return IN;
    return mregs[a];
  endfunction

  function automatic logic [XW-1:0] m_beat(input int b);
    logic [XW-1:0] r;
    for (int j = 0; j < RPB; j++) r[j*DW +: DW] = mregs[b*RPB + j];
    return r;
  endfunction

  // Observation counters, cleared by the stimulus process.
  int            busy_cnt, done_cnt, s_acc, r_acc;
  logic [XW-1:0] sbeats [NB];

  task automatic clr();
    busy_cnt = 0; done_cnt = 0; s_acc = 0; r_acc = 0;
    for (int k = 0; k < NB; k++) sbeats[k] = '0;
  endtask

  // Compare, observe, then advance the model with the inputs of this cycle.
  initial begin
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    mmode = 0; mbeat = 0; mdone = 0;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      chk("out1", OUT1, m_read(OUTADDRESS1));
      chk("out2", OUT2, m_read(OUTADDRESS2));
      chk("busywait", xif.BUSYWAIT, (mmode != 0) || mdone);
      chk("done", xif.DONE, mdone);
      chk("save_valid", xif.SAVE_VALID, mmode == 1);
      chk("save_data", xif.SAVE_DATA, (mmode == 1) ? m_beat(mbeat) : '0);
      chk("restore_ready", xif.RESTORE_READY, mmode == 2);

      if (xif.BUSYWAIT) busy_cnt++;
      if (xif.DONE) done_cnt++;
      if (xif.SAVE_VALID && xif.SAVE_READY) begin
        if (s_acc < NB) sbeats[s_acc] = xif.SAVE_DATA;
        s_acc++;
      end
      if (xif.RESTORE_VALID && xif.RESTORE_READY) r_acc++;

      if (RESET) begin
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        mmode = 0; mbeat = 0; mdone = 0;
      end else begin
        mdone = 0;
        if (mmode == 0) begin
          if (WRITE && INADDRESS != 0) mregs[INADDRESS] = IN;
          if (xif.SAVE_REQ) begin mmode = 1; mbeat = 0; end
          else if (xif.RESTORE_REQ) begin mmode = 2; mbeat = 0; end
        end else if (mmode == 1) begin
          if (xif.SAVE_READY) mbeat++;
        end else begin
          if (xif.RESTORE_VALID) begin
            for (int j = 0; j < RPB; j++)
              if (mbeat*RPB + j != 0) mregs[mbeat*RPB + j] = xif.RESTORE_DATA[j*DW +: DW];
            mbeat++;
          end
        end
        if (mmode != 0 && mbeat == NB) begin
          mmode = 0; mbeat = 0; mdone = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    if (done_cnt == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: actual=no DONE required=DONE within %0d cycles", nm, budget);
    end
  endtask

  task automatic timeout_chk(input string nm, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual=timeout required=completion", nm);
    end
  endtask

  logic [XW-1:0] rdata [NB];
  logic [XW-1:0] exp_b;
  int            n;

  initial begin
    RESET = 1'b1; WRITE = 1'b0; INADDRESS = '0; IN = '0;
    OUTADDRESS1 = '0; OUTADDRESS2 = '0;
    xif.SAVE_REQ = 1'b0; xif.RESTORE_REQ = 1'b0; xif.SAVE_READY = 1'b0;
    xif.RESTORE_DATA = '0; xif.RESTORE_VALID = 1'b0;
    clr();
    repeat (2) tick();
    OUTADDRESS1 = 5'd5;
    #1 chk("reset_reg5", OUT1, 0);
    RESET = 1'b0;

    // Write, bypass and x0
    WRITE = 1'b1; INADDRESS = 5'd5; IN = 32'hDEADBEEF;
    #1 chk("bypass_reg5", OUT1, 32'hDEADBEEF);
    tick(); WRITE = 1'b0;
    #1 chk("read_reg5", OUT1, 32'hDEADBEEF);
    OUTADDRESS2 = 5'd0; WRITE = 1'b1; INADDRESS = 5'd0; IN = '1;
    #1 chk("bypass_reg0", OUT2, 0);
    tick(); WRITE = 1'b0;
    #1 chk("read_reg0", OUT2, 0);

    for (int i = 0; i < NR; i++) begin
      WRITE = 1'b1; INADDRESS = 5'(i); IN = 32'(i + 1); tick();
    end
    WRITE = 1'b0;

    // Save, no backpressure
    clr(); xif.SAVE_READY = 1'b1; xif.SAVE_REQ = 1'b1; tick(); xif.SAVE_REQ = 1'b0;
    wait_done("save1", 40); tick();
    chk("save1_beat0", sbeats[0], 128'h00000004_00000003_00000002_00000000);
    chk("save1_beat7", sbeats[7], 128'h00000020_0000001f_0000001e_0000001d);
    chk("save1_accepts", s_acc, 8);
    chk("save1_busy_cycles", busy_cnt, 9);
    chk("save1_done_pulses", done_cnt, 1);

    // Save with toggling ready; writes during save must be dropped
    clr(); OUTADDRESS1 = 5'd10; xif.SAVE_READY = 1'b0; xif.SAVE_REQ = 1'b1; tick();
    xif.SAVE_REQ = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 60) begin
      xif.SAVE_READY = ~xif.SAVE_READY;
      WRITE = (n < 6); INADDRESS = 5'd10; IN = 32'h5555;
      tick(); n++;
    end
    WRITE = 1'b0;
    timeout_chk("save2_done", done_cnt != 0);
    tick();
    chk("save2_accepts", s_acc, 8);
    chk("save2_beat2", sbeats[2], 128'h0000000c_0000000b_0000000a_00000009);
    #1 chk("save2_reg10_kept", OUT1, 32'd11);

    // Restore with random gaps
    for (int k = 0; k < NB; k++) rdata[k] = {$urandom, $urandom, $urandom, $urandom};
    clr(); xif.RESTORE_REQ = 1'b1; tick(); xif.RESTORE_REQ = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 100) begin
      xif.RESTORE_VALID = 1'($urandom_range(0, 1));
      xif.RESTORE_DATA = rdata[(r_acc < NB) ? r_acc : 0];
      tick(); n++;
    end
    xif.RESTORE_VALID = 1'b0;
    timeout_chk("restore_done", done_cnt != 0);
    chk("restore_accepts", r_acc, 8);
    OUTADDRESS2 = 5'd0; OUTADDRESS1 = 5'd9;
    #1 chk("restore_reg0", OUT2, 0);
    chk("restore_reg9", OUT1, rdata[2][63:32]);

    // Echo save
    clr(); xif.SAVE_READY = 1'b1; xif.SAVE_REQ = 1'b1; tick(); xif.SAVE_REQ = 1'b0;
    wait_done("echo", 40); tick();
    for (int k = 0; k < NB; k++) begin
      exp_b = rdata[k];
      if (k == 0) exp_b[31:0] = '0;
      chk($sformatf("echo_beat%0d", k), sbeats[k], exp_b);
    end

    // Simultaneous requests with a same-cycle write
    clr(); WRITE = 1'b1; INADDRESS = 5'd3; IN = 32'd7;
    xif.SAVE_REQ = 1'b1; xif.RESTORE_REQ = 1'b1; xif.SAVE_READY = 1'b1;
    xif.RESTORE_VALID = 1'b1;
    tick();
    WRITE = 1'b0; xif.SAVE_REQ = 1'b0; xif.RESTORE_REQ = 1'b0;
    wait_done("both_req", 40); tick();
    xif.RESTORE_VALID = 1'b0;
    chk("both_req_reg3", sbeats[0][127:96], 32'd7);
    chk("both_req_accepts", s_acc, 8);
    chk("both_req_no_restore", r_acc, 0);

    // Reset at beat 4 of a restore
    clr(); xif.RESTORE_REQ = 1'b1; tick(); xif.RESTORE_REQ = 1'b0;
    xif.RESTORE_VALID = 1'b1; n = 0;
    while (r_acc < 4 && n < 20) begin
      xif.RESTORE_DATA = {$urandom, $urandom, $urandom, $urandom};
      tick(); n++;
    end
    timeout_chk("reset_mid_reach_beat4", r_acc >= 4);
    RESET = 1'b1; xif.RESTORE_VALID = 1'b0; tick(); RESET = 1'b0;
    OUTADDRESS1 = 5'd9;
    #1 chk("reset_busywait", xif.BUSYWAIT, 0);
    chk("reset_restore_ready", xif.RESTORE_READY, 0);
    chk("reset_reg9", OUT1, 0);
    repeat (3) tick();
    chk("reset_no_done", done_cnt, 0);
    WRITE = 1'b1; INADDRESS = 5'd5; IN = 32'hA5; tick();
    INADDRESS = 5'd30; IN = 32'h3C; tick(); WRITE = 1'b0;
    clr(); xif.SAVE_REQ = 1'b1; tick(); xif.SAVE_REQ = 1'b0;
    wait_done("post_reset_save", 40); tick();
    chk("post_reset_accepts", s_acc, 8);
    chk("post_reset_beat1", sbeats[1], 128'h00000000_00000000_000000a5_00000000);
    chk("post_reset_beat7", sbeats[7], 128'h00000000_0000003c_00000000_00000000);

    // Random traffic, checked every cycle by the model
    for (int c = 0; c < 400; c++) begin
      RESET = ($urandom_range(0, 199) == 0);
      WRITE = 1'($urandom_range(0, 1));
      INADDRESS = 5'($urandom); IN = $urandom;
      OUTADDRESS1 = 5'($urandom); OUTADDRESS2 = 5'($urandom);
      xif.SAVE_REQ = ($urandom_range(0, 15) == 0);
      xif.RESTORE_REQ = ($urandom_range(0, 15) == 0);
      xif.SAVE_READY = 1'($urandom_range(0, 1));
      xif.RESTORE_VALID = 1'($urandom_range(0, 1));
      xif.RESTORE_DATA = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    RESET = 1'b0; WRITE = 1'b0; xif.SAVE_REQ = 1'b0; xif.RESTORE_REQ = 1'b0;
    xif.SAVE_READY = 1'b1; xif.RESTORE_VALID = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
